// File: rtl/control_sequencer.sv
// Fetch/decode/execute control unit for the 8-bit CPU: owns IR, T-state counter and
// fetch address, and decodes them into one-hot bus/register strobes.
module control_sequencer #(
  parameter int unsigned T_MAX       = 5,
  parameter bit          HALT_ON_END = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] bus_in,
  input  logic [3:0] pc_a,
  input  logic       cf,
  input  logic       zf,
  output logic       pcen,
  output logic       pc_load,
  output logic [3:0] pc_in,
  output logic       pc_oe,
  output logic       mar_load,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       ir_oe,
  output logic       ir_load,
  output logic       a_load,
  output logic       a_oe,
  output logic       b_load,
  output logic       alu_oe,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state,
  output logic [3:0] opcode
);

  localparam int unsigned TW  = 3;
  localparam int unsigned IRW = 8;
  localparam int unsigned AW  = 4;

  logic [TW-1:0]  t,  t_nxt;
  logic [IRW-1:0] ir, ir_nxt;
  logic [AW-1:0]  fa, fa_nxt;
  logic           halted_nxt;
  logic           active_c;
  logic           end_c;
  logic           hlt_c;
  logic [3:0]     op;

  assign op       = ir[7:4];
  assign active_c = reset && run && !halted;
  assign pc_in    = ir[3:0];
  assign t_state  = t;
  assign opcode   = op;

  // State register; reset is folded into the next-state logic (synchronous)
  always_ff @(posedge clk) begin
    t      <= t_nxt;
    ir     <= ir_nxt;
    fa     <= fa_nxt;
    halted <= halted_nxt;
  end

  // Strobe decode and next-state
  always_comb begin
    pcen       = 1'b0;
    pc_load    = 1'b0;
    pc_oe      = 1'b0;
    mar_load   = 1'b0;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    ir_oe      = 1'b0;
    ir_load    = 1'b0;
    a_load     = 1'b0;
    a_oe       = 1'b0;
    b_load     = 1'b0;
    alu_oe     = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    end_c      = 1'b0;
    hlt_c      = 1'b0;
    t_nxt      = t;
    ir_nxt     = ir;
    fa_nxt     = fa;
    halted_nxt = halted;

    if (active_c) begin
      if (t == TW'(0)) begin
        pc_oe    = 1'b1;
        mar_load = 1'b1;
      end else if (t == TW'(1)) begin
        ram_oe  = 1'b1;
        ir_load = 1'b1;
        pcen    = 1'b1;
      end else begin
        case (op)
          4'h1: begin
            if (t == TW'(2)) begin
              ir_oe = 1'b1; mar_load = 1'b1;
            end else begin
              ram_oe = 1'b1; a_load = 1'b1; end_c = 1'b1;
            end
          end
          4'h2, 4'h3: begin
            if (t == TW'(2)) begin
              ir_oe = 1'b1; mar_load = 1'b1;
            end else if (t == TW'(3)) begin
              ram_oe = 1'b1; b_load = 1'b1;
            end else begin
              alu_oe = 1'b1; a_load = 1'b1; flags_load = 1'b1;
              alu_sub = (op == 4'h3);
              end_c = 1'b1;
            end
          end
          4'h4: begin
            if (t == TW'(2)) begin
              ir_oe = 1'b1; mar_load = 1'b1;
            end else begin
              a_oe = 1'b1; ram_we = 1'b1; end_c = 1'b1;
            end
          end
          4'h5: begin
            ir_oe = 1'b1; a_load = 1'b1; end_c = 1'b1;
          end
          4'h6: begin
            pc_load = 1'b1; end_c = 1'b1;
          end
          4'h7: begin
            pc_load = cf; end_c = 1'b1;
          end
          4'h8: begin
            pc_load = zf; end_c = 1'b1;
          end
          4'hE: begin
            a_oe = 1'b1; out_load = 1'b1; end_c = 1'b1;
          end
          4'hF: hlt_c = 1'b1;
          default: end_c = 1'b1;
        endcase
        if (t >= TW'(T_MAX)) end_c = 1'b1;
      end

      if (t == TW'(0)) fa_nxt = pc_a;
      if (t == TW'(1)) ir_nxt = bus_in;
      // HLT freezes T in place; otherwise advance or wrap to T0
      if (hlt_c) begin
        halted_nxt = 1'b1;
      end else if (end_c) begin
        t_nxt = '0;
        if (HALT_ON_END && (fa == AW'(15)) && !pc_load) halted_nxt = 1'b1;
      end else begin
        t_nxt = TW'(t + TW'(1));
      end
    end

    if (!reset) begin
      t_nxt      = '0;
      ir_nxt     = '0;
      fa_nxt     = '0;
      halted_nxt = 1'b0;
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute control unit for the 8-bit CPU.
- Sits directly upstream of the 4-bit program counter: drives its PCEN, LOAD and IN, and reads back its address output A.
- Owns the instruction register and a T-state counter. Decodes 8-bit instructions (opcode[7:4], operand[3:0]) into one-hot bus/register strobes.

Parameters:
- T_MAX, 5, index of the last T-state (T0..T5). Must be ≥4.
- HALT_ON_END, 1, when 1, halt after completing a non-jumping instruction fetched from address 15.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- RESET  in  1  reset, synchronous, active-low
- RUN  in  1  advance enable; 0 freezes the sequencer
- BUS_IN  in  8  data bus; IR source in T1
- PC_A  in  4  current program counter value
- CF  in  1  carry flag
- ZF  in  1  zero flag
- PCEN  out  1  PC increment enable
- PC_LOAD  out  1  PC parallel load
- PC_IN  out  4  PC load value, always IR[3:0]
- PC_OE  out  1  PC drives bus
- MAR_LOAD  out  1  memory address register load
- RAM_OE  out  1  RAM drives bus
- RAM_WE  out  1  RAM write
- IR_OE  out  1  IR[3:0] drives bus, zero-extended
- IR_LOAD  out  1  IR load strobe (observability)
- A_LOAD  out  1  accumulator load
- A_OE  out  1  accumulator drives bus
- B_LOAD  out  1  B register load
- ALU_OE  out  1  ALU result drives bus
- ALU_SUB  out  1  ALU subtract select
- FLAGS_LOAD  out  1  flag register load
- OUT_LOAD  out  1  output register load
- HALTED  out  1  sticky halt
- T_STATE  out  3  current T-state
- OPCODE  out  4  IR[7:4]

Behaviour:
Registers and reset:
- State is held in T (3b), IR (8b), FA (fetch address, 4b) and HALTED.
- RESET=0 at a clock edge sets T=0, IR=0x00, FA=0 and HALTED=0.
- While RESET=0, all strobe outputs are forced to 0. T_STATE=0 and OPCODE=0 after that edge.

Strobe decode:
- All strobes are combinational from T, IR, CF and ZF.
- All strobes are gated to 0 when RUN=0, HALTED=1 or RESET=0.

Fetch (every instruction):
- T0: PC_OE and MAR_LOAD. FA<=PC_A at the edge.
- T1: RAM_OE, IR_LOAD and PCEN. IR<=BUS_IN at the edge.

Execute (T2 onward); "end" means T<=0 at the next edge, otherwise T<=T+1:
- 0 NOP: T2 end.
- 1 LDA: T2 IR_OE+MAR_LOAD; T3 RAM_OE+A_LOAD, end.
- 2 ADD: T2 IR_OE+MAR_LOAD; T3 RAM_OE+B_LOAD; T4 ALU_OE+A_LOAD+FLAGS_LOAD, end.
- 3 SUB: same as ADD, with ALU_SUB=1 in T4 only.
- 4 STA: T2 IR_OE+MAR_LOAD; T3 A_OE+RAM_WE, end.
- 5 LDI: T2 IR_OE+A_LOAD, end.
- 6 JMP: T2 PC_LOAD, end.
- 7 JC: T2 PC_LOAD if CF=1, end.
- 8 JZ: T2 PC_LOAD if ZF=1, end.
- E OUT: T2 A_OE+OUT_LOAD, end.
- F HLT: T2 HALTED<=1 at the edge.
- 9–D: treated as NOP.
- T never exceeds T_MAX. Reaching T_MAX forces end.

Halt and freeze:
- HALTED is sticky. T and IR freeze, and only RESET clears it.
- RUN=0: T, IR and FA hold. The instruction resumes at the same T-state when RUN returns to 1.

End of memory (HALT_ON_END=1):
- The PC saturates at 15.
- At the end edge of an instruction with FA=15: HALTED<=1 unless PC_LOAD was asserted in that instruction.
- HLT at 15 halts normally.

Simultaneous events:
- RESET=0 overrides RUN and HALTED.
- RESET mid-instruction aborts it: the next state is T0, and no strobe issues in the reset cycle.
- PC_LOAD and PCEN are never asserted in the same cycle.

Test Plan:
1. Reset, RUN=1, BUS_IN=0x5A during T1 -> T0: PC_OE+MAR_LOAD; T1: RAM_OE+IR_LOAD+PCEN; T2: IR_OE+A_LOAD, OPCODE=5; T_STATE=0 on the 4th cycle.
2. ADD 0x27 -> 5-cycle instruction; T4 has ALU_OE+A_LOAD+FLAGS_LOAD with ALU_SUB=0. SUB 0x37 -> identical, except ALU_SUB=1 in T4 only.
3. JC 0x7C with CF=0 -> T2 has no strobes and PC_LOAD=0. With CF=1 -> T2 has PC_LOAD=1, PC_IN=0xC. JZ 0x83 with ZF=1 -> PC_LOAD=1, PC_IN=0x3.
4. HLT 0xF0 -> HALTED=1 after the T2 edge; T_STATE stays 2 and all strobes stay 0 for 10 cycles regardless of RUN. One cycle of RESET=0 -> HALTED=0, T_STATE=0.
5. PC_A=15 at T0 with NOP 0x00 -> HALTED=1 after the T2 edge. PC_A=15 with JMP 0x63 -> HALTED=0, PC_LOAD in T2, next T0 issues normally.
6. LDA 0x1E, RUN=0 for 4 cycles at T3 -> T_STATE holds 3 with strobes 0; on RUN=1 -> RAM_OE+A_LOAD once, then T0. Repeat with RESET=0 at T3 -> next T_STATE=0, OPCODE=0, no A_LOAD.
